// File: rtl/pll_lock_supervisor_if.sv
`default_nettype none
// ============================================================================
// pll_lock_supervisor_if : PLL lock status / system reset bundle
// Revision 1.0
// ============================================================================
interface pll_lock_supervisor_if #(
    parameter int CNT_WIDTH = 8
);
    logic                 locked;
    logic                 clr;
    logic                 rst_out;
    logic                 ready;
    logic                 fault;
    logic [CNT_WIDTH-1:0] loss_count;

    // master: the supervisor itself; slave: the PLL/software side
    modport master (
        input  locked,
        input  clr,
        output rst_out,
        output ready,
        output fault,
        output loss_count
    );

    modport slave (
        output locked,
        output clr,
        input  rst_out,
        input  ready,
        input  fault,
        input  loss_count
    );
endinterface
`default_nettype wire

// File: rtl/pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
// pll_lock_supervisor : holds PLL-domain reset until lock is stable, flags
// acquisition timeouts. PLL_SUPERVISOR_LOSS_COUNT_EN builds the loss counter.
// Revision 1.0
// ============================================================================
module pll_lock_supervisor #(
    parameter int SYNC_STAGES    = 2,
    parameter int HOLD_CYCLES    = 16,
    parameter int STABLE_CYCLES  = 1024,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_WIDTH      = 8
) (
    input  wire                    clk,
    input  wire                    reset,
    pll_lock_supervisor_if.master  bus
);
    localparam int HW = (HOLD_CYCLES    > 1) ? $clog2(HOLD_CYCLES)    : 1;
    localparam int SW = (STABLE_CYCLES  > 1) ? $clog2(STABLE_CYCLES)  : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [HW-1:0] C_HOLD_LAST   = HW'(HOLD_CYCLES - 1);
    localparam logic [SW-1:0] C_STABLE_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] C_TMO_LAST    = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_HOLD      = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_SETTLE    = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [HW-1:0]          hold_q, hold_d;
    logic [SW-1:0]          stable_q, stable_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic                   fault_q, fault_d;
    logic                   rst_out_q, ready_q;
    logic                   locked_s;
    logic                   loss_inc;

    assign locked_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        stable_d = stable_q;
        tmo_d    = tmo_q;
        fault_d  = fault_q;
        loss_inc = 1'b0;

        case (state_q)
            ST_HOLD: begin
                tmo_d = '0;
                if (hold_q == C_HOLD_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                if (tmo_q != C_TMO_LAST) tmo_d = tmo_q + 1'b1;
                if (locked_s) begin
                    state_d  = ST_SETTLE;
                    stable_d = '0;
                end
            end
            ST_SETTLE: begin
                if (tmo_q != C_TMO_LAST) tmo_d = tmo_q + 1'b1;
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (stable_q == C_STABLE_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    stable_d = stable_q + 1'b1;
                end
            end
            default: begin
                tmo_d = '0;
                if (!locked_s) begin
                    state_d  = ST_HOLD;
                    hold_d   = '0;
                    loss_inc = 1'b1;
                end
            end
        endcase

        // Timeout only flags; the FSM keeps trying to acquire lock
        if ((state_q == ST_WAIT_LOCK || state_q == ST_SETTLE) && tmo_q == C_TMO_LAST)
            fault_d = 1'b1;
        if (bus.clr)
            fault_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_HOLD;
            sync_q    <= '0;
            hold_q    <= '0;
            stable_q  <= '0;
            tmo_q     <= '0;
            fault_q   <= 1'b0;
            rst_out_q <= 1'b1;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= {sync_q[SYNC_STAGES-2:0], bus.locked};
            hold_q    <= hold_d;
            stable_q  <= stable_d;
            tmo_q     <= tmo_d;
            fault_q   <= fault_d;
            rst_out_q <= (state_d != ST_RUN);
            ready_q   <= (state_d == ST_RUN);
        end
    end

    assign bus.rst_out = rst_out_q;
    assign bus.ready   = ready_q;
    assign bus.fault   = fault_q;

`ifdef PLL_SUPERVISOR_LOSS_COUNT_EN
    logic [CNT_WIDTH-1:0] loss_q;

    always_ff @(posedge clk) begin
        if (reset || bus.clr) begin
            loss_q <= '0;
        end else if (loss_inc && loss_q != {CNT_WIDTH{1'b1}}) begin
            loss_q <= loss_q + 1'b1;
        end
    end

    assign bus.loss_count = loss_q;
`else
    assign bus.loss_count = {CNT_WIDTH{1'b0}};
`endif

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
// tb_pll_lock_supervisor : directed bench, small parameter set
// Revision 1.0
// ============================================================================
module tb_pll_lock_supervisor;
    localparam int C_CW = 2;
`ifdef PLL_SUPERVISOR_LOSS_COUNT_EN
    localparam bit C_LC_EN = 1'b1;
`else
    localparam bit C_LC_EN = 1'b0;
`endif

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    pll_lock_supervisor_if #(.CNT_WIDTH(C_CW)) bus ();

    pll_lock_supervisor #(
        .SYNC_STAGES   (2),
        .HOLD_CYCLES   (4),
        .STABLE_CYCLES (8),
        .TIMEOUT_CYCLES(32),
        .CNT_WIDTH     (C_CW)
    ) u_dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_cnt(input int n);
        if (!C_LC_EN) return 32'd0;
        return (n > 3) ? 32'd3 : 32'(n);
    endfunction

    // Lock loss from RUN with relock right behind it; RUN again 16 edges after the drop
    task automatic lose_relock(input int n_loss);
        bus.locked = 1'b0;
        tick(3);
        check("loss_rst_out", 32'(bus.rst_out), 32'd1);
        check("loss_count", 32'(bus.loss_count), exp_cnt(n_loss));
        bus.locked = 1'b1;
        tick(13);
        check("relock_ready", 32'(bus.ready), 32'd1);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        reset      = 1'b1;
        bus.locked = 1'b0;
        bus.clr    = 1'b0;
        tick(2);
        check("rst_rst_out", 32'(bus.rst_out), 32'd1);
        check("rst_ready", 32'(bus.ready), 32'd0);
        check("rst_fault", 32'(bus.fault), 32'd0);
        check("rst_loss", 32'(bus.loss_count), 32'd0);

        // Acquisition timeout with locked held low
        reset = 1'b0;
        tick(35);
        check("tmo_fault_e35", 32'(bus.fault), 32'd0);
        tick(1);
        check("tmo_fault_e36", 32'(bus.fault), 32'd1);
        check("tmo_rst_out", 32'(bus.rst_out), 32'd1);
        tick(4);
        check("tmo_fault_sticky", 32'(bus.fault), 32'd1);
        bus.locked = 1'b1;
        tick(10);
        check("tmo_ready_e50", 32'(bus.ready), 32'd0);
        tick(1);
        check("tmo_ready_e51", 32'(bus.ready), 32'd1);
        check("tmo_rst_out_e51", 32'(bus.rst_out), 32'd0);
        check("tmo_fault_in_run", 32'(bus.fault), 32'd1);
        bus.clr = 1'b1;
        tick(1);
        bus.clr = 1'b0;
        check("clr_fault", 32'(bus.fault), 32'd0);
        check("clr_loss", 32'(bus.loss_count), 32'd0);
        check("clr_ready", 32'(bus.ready), 32'd1);

        // Reset release with locked high throughout
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(12);
        check("up_rst_out_e12", 32'(bus.rst_out), 32'd1);
        tick(1);
        check("up_rst_out_e13", 32'(bus.rst_out), 32'd0);
        check("up_ready_e13", 32'(bus.ready), 32'd1);
        check("up_fault", 32'(bus.fault), 32'd0);

        // Lock loss for 5 cycles
        bus.locked = 1'b0;
        tick(2);
        check("ll_rst_out_e2", 32'(bus.rst_out), 32'd0);
        tick(1);
        check("ll_rst_out_e3", 32'(bus.rst_out), 32'd1);
        check("ll_ready_e3", 32'(bus.ready), 32'd0);
        check("ll_loss", 32'(bus.loss_count), exp_cnt(1));
        tick(2);
        bus.locked = 1'b1;
        tick(10);
        check("ll_rst_out_e15", 32'(bus.rst_out), 32'd1);
        tick(1);
        check("ll_rst_out_e16", 32'(bus.rst_out), 32'd0);
        check("ll_loss_after", 32'(bus.loss_count), exp_cnt(1));

        // Saturation of the loss counter
        lose_relock(2);
        lose_relock(3);
        lose_relock(4);

        // clr on the same edge as a further loss
        bus.locked = 1'b0;
        tick(2);
        bus.clr = 1'b1;
        tick(1);
        bus.clr = 1'b0;
        check("clr_vs_inc_loss", 32'(bus.loss_count), 32'd0);
        check("clr_vs_inc_rst", 32'(bus.rst_out), 32'd1);
        bus.locked = 1'b1;
        tick(13);
        check("clr_vs_inc_ready", 32'(bus.ready), 32'd1);

        // One-cycle reset while in RUN
        lose_relock(1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("mid_rst_rst_out", 32'(bus.rst_out), 32'd1);
        check("mid_rst_ready", 32'(bus.ready), 32'd0);
        check("mid_rst_loss", 32'(bus.loss_count), 32'd0);
        tick(12);
        check("mid_rst_e12", 32'(bus.rst_out), 32'd1);
        tick(1);
        check("mid_rst_e13", 32'(bus.rst_out), 32'd0);

        // Glitch during SETTLE restarts the stable window
        bus.locked = 1'b0;
        reset      = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(4);
        bus.locked = 1'b1;
        tick(8);
        bus.locked = 1'b0;
        tick(2);
        bus.locked = 1'b1;
        check("gl_rst_out_e14", 32'(bus.rst_out), 32'd1);
        tick(1);
        check("gl_rst_out_e15", 32'(bus.rst_out), 32'd1);
        tick(9);
        check("gl_rst_out_e24", 32'(bus.rst_out), 32'd1);
        tick(1);
        check("gl_rst_out_e25", 32'(bus.rst_out), 32'd0);
        check("gl_ready_e25", 32'(bus.ready), 32'd1);
        check("gl_fault", 32'(bus.fault), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
